// File: rtl/stim_sequencer.sv
// stim_sequencer: sweeps (a,b) over 00..11 with a programmable dwell and logs partS responses
module stim_sequencer #(
  parameter int DWELL  = 10,
  parameter int PASSES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        hold,
  input  logic        y1,
  input  logic        y2,
  input  logic        y3,
  output logic        a,
  output logic        b,
  output logic [1:0]  vec_idx,
  output logic        sample,
  output logic        busy,
  output logic        done,
  output logic [11:0] resp_log
);
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  localparam logic [3:0] PASS_LAST = 4'(PASSES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    pass_q;
  logic [1:0]    vec_q;
  logic          busy_q, done_q;
  logic [11:0]   log_q;
  assign sample   = state_q == RUN && !hold && cnt_q == LAST;
  assign vec_idx  = vec_q;
  assign a        = vec_q[1];
  assign b        = vec_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign resp_log = log_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pass_q  <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      log_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q <= RUN;
          cnt_q   <= '0;
          pass_q  <= '0;
          vec_q   <= '0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          log_q   <= '0;
        end
        RUN: if (!hold) begin
          if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
          else begin
            cnt_q <= '0;
            log_q[3*vec_q +: 3] <= {y1, y2, y3};
            if (vec_q != 2'd3) vec_q <= vec_q + 1'b1;
            else if (pass_q != PASS_LAST) begin
              vec_q  <= '0;
              pass_q <= pass_q + 1'b1;
            end else begin
              state_q <= DONE;
              vec_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stim_sequencer.sv
// tb_stim_sequencer: directed checks of sweep timing, hold, reset and restart on two configurations
module tb_stim_sequencer;
  logic clk = 1'b0;
  logic reset, start, hold, reset2, start2;
  logic a, b, sample, busy, done, a2, b2, sample2, busy2, done2;
  logic [1:0] vec_idx, vec_idx2;
  logic [11:0] resp_log, resp_log2;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  stim_sequencer #(.DWELL(10), .PASSES(1)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .y1(a & b), .y2(a | b), .y3(a ^ b),
    .a(a), .b(b), .vec_idx(vec_idx), .sample(sample), .busy(busy), .done(done), .resp_log(resp_log)
  );
  stim_sequencer #(.DWELL(1), .PASSES(3)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .hold(1'b0),
    .y1(a2 & b2), .y2(a2 | b2), .y3(a2 ^ b2),
    .a(a2), .b(b2), .vec_idx(vec_idx2), .sample(sample2), .busy(busy2), .done(done2), .resp_log(resp_log2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_vec"}, vec_idx, 0);
    chk({tag, "_ab"}, {a, b}, 0);
    chk({tag, "_sample"}, sample, 0);
    chk({tag, "_log"}, resp_log, 0);
  endtask
  // e counts unheld RUN cycles, which fixes the expected vector and capture point
  task automatic run_sweep(input int h0, input int h1, input bit keep_start);
    int e = 0;
    int k = 0;
    int exp_vec;
    start = 1'b1;
    tick();
    if (!keep_start) start = 1'b0;
    chk("entry_busy", busy, 1);
    chk("entry_done", done, 0);
    chk("entry_log", resp_log, 0);
    while (e < 40 && k < 100) begin
      hold = k >= h0 && k < h1;
      exp_vec = e / 10;
      chk("run_vec", vec_idx, exp_vec);
      chk("run_ab", {a, b}, exp_vec);
      chk("run_sample", sample, !hold && e % 10 == 9);
      chk("run_done", done, 0);
      tick();
      if (!hold) e++;
      k++;
    end
    hold = 1'b0;
    chk("run_len", k, 40 + h1 - h0);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_ab", {a, b}, 0);
    chk("end_log", resp_log, 12'hCD8);
    start = 1'b0;
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; hold = 1'b0; reset2 = 1'b1; start2 = 1'b0;
    tick();
    tick();
    check_idle("reset");
    chk("reset2_log", resp_log2, 0);
    reset = 1'b0; reset2 = 1'b0;
    tick();
    check_idle("idle");
    hold = 1'b1;
    tick();
    hold = 1'b0;
    check_idle("idle_hold");
    run_sweep(0, 0, 0);
    tick();
    chk("done_stays", done, 1);
    run_sweep(23, 28, 0);
    run_sweep(0, 0, 1);
    tick();
    chk("no_restart_done", done, 1);
    chk("no_restart_busy", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 17; k++) tick();
    chk("mid_vec", vec_idx, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("mid_reset");
    tick();
    chk("mid_reset_stay", busy, 0);
    run_sweep(0, 0, 0);
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    check_idle("rst_start");
    tick();
    chk("rst_start_stay", busy, 0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("d1_vec", vec_idx2, k % 4);
      chk("d1_sample", sample2, 1);
      chk("d1_done", done2, 0);
      tick();
    end
    chk("d1_end_done", done2, 1);
    chk("d1_end_busy", busy2, 0);
    chk("d1_end_sample", sample2, 0);
    chk("d1_end_log", resp_log2, 12'hCD8);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
